// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the rv_mem_resp memory responder.
// Holds the FSM state encoding, the wait-counter width and the access-legality check.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_RESP
    } mem_state_e;

    // Wide enough for the largest allowed wait-state count (15).
    localparam int CNT_W = 4;

    // True when the byte address is misaligned or beyond the stored words.
    function automatic logic addr_err(input logic [63:0] a, input int unsigned words);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 64'(words));
    endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register can be cleared so an error response returns zero data.
module rv_mem_array
    import rv_mem_pkg::*;
#(
    parameter int DPWIDTH  = 32,
    parameter int MEMWORDS = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DPWIDTH/8-1:0]         wen,
    input  logic                         ren,
    input  logic                         clr,
    input  logic [$clog2(MEMWORDS)-1:0]  idx,
    input  logic [DPWIDTH-1:0]           wdata,
    output logic [DPWIDTH-1:0]           q
);

    localparam int BW = DPWIDTH / 8;

    logic [DPWIDTH-1:0] mem [MEMWORDS];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BW; i++) begin
            if (wen[i]) begin
                mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ren) begin
            q <= mem[idx];
        end
    end

endmodule

// File: rtl/rv_mem_resp.sv
// Memory responder: captures one request, waits LATENCY cycles, then performs
// the access and returns a one-cycle ready pulse with an error flag.
module rv_mem_resp
    import rv_mem_pkg::*;
#(
    parameter int DPWIDTH  = 32,
    parameter int MEMWORDS = 1024,
    parameter int LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [DPWIDTH/8-1:0]  be,
    input  logic [DPWIDTH-1:0]    addr,
    input  logic [DPWIDTH-1:0]    wdata,
    output logic [DPWIDTH-1:0]    rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int AW = $clog2(MEMWORDS);
    localparam int BW = DPWIDTH / 8;

    mem_state_e         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               cap, resp, acc_err;
    logic               we_q;
    logic [BW-1:0]      be_q;
    logic [DPWIDTH-1:0] addr_q, wdata_q;
    logic [BW-1:0]      wen;
    logic               ren, clr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cap      = 1'b0;
        resp     = 1'b0;
        unique case (state)
            MS_IDLE: begin
                if (req) begin
                    cap      = 1'b1;
                    cnt_nx   = CNT_W'(LATENCY);
                    state_nx = (LATENCY > 0) ? MS_WAIT : MS_RESP;
                end
            end
            MS_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx = MS_RESP;
                end
            end
            MS_RESP: begin
                resp     = 1'b1;
                state_nx = MS_IDLE;
            end
            default: state_nx = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MS_IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= resp;
            err   <= resp & acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            we_q    <= we;
            be_q    <= be;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign acc_err = addr_err(64'(addr_q), MEMWORDS);

    // A reset coinciding with the response edge must still suppress the write.
    assign wen = (resp && !rst && we_q && !acc_err) ? be_q : '0;
    assign ren = resp && !we_q && !acc_err;
    assign clr = resp && acc_err;

    rv_mem_array #(
        .DPWIDTH  (DPWIDTH),
        .MEMWORDS (MEMWORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .ren   (ren),
        .clr   (clr),
        .idx   (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .q     (rdata)
    );

endmodule

// File: tb/tb_rv_mem_resp.sv
// Self-checking bench for rv_mem_resp: a LATENCY=2 instance and a LATENCY=0
// instance, checked against a word-array reference model.
module tb_rv_mem_resp;

    logic        clk = 1'b0;
    logic        rst;

    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err;

    logic        req0, we0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0;

    int nassert = 0;
    int nfail   = 0;

    logic [31:0] mdl  [1024];
    logic [31:0] mdl0 [1024];
    logic [31:0] last2, last0;

    always #5 clk = ~clk;

    rv_mem_resp #(.DPWIDTH(32), .MEMWORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
    );

    rv_mem_resp #(.DPWIDTH(32), .MEMWORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .be(be0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access on either instance, checked against the model.
    task automatic access(input bit d0, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd);
        int          k;
        bit          got;
        bit          exp_err;
        logic [31:0] exp_rd;
        int          wi;
        exp_err = (a[1:0] != 2'b00) || (a >= 32'h1000);
        wi      = int'(a[11:2]);
        if (exp_err)  exp_rd = 32'h0;
        else if (w)   exp_rd = d0 ? last0 : last2;
        else          exp_rd = d0 ? mdl0[wi] : mdl[wi];
        if (w && !exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) begin
                    if (d0) mdl0[wi][i*8 +: 8] = wd[i*8 +: 8];
                    else    mdl[wi][i*8 +: 8]  = wd[i*8 +: 8];
                end
            end
        end
        @(negedge clk);
        if (d0) begin req0 = 1; we0 = w; be0 = b; addr0 = a; wdata0 = wd; end
        else    begin req  = 1; we  = w; be  = b; addr  = a; wdata  = wd; end
        @(posedge clk);
        @(negedge clk);
        // Scramble the bus after capture; the responder must use latched values.
        if (d0) begin req0 = 0; we0 = 1'($urandom); be0 = 4'($urandom); addr0 = $urandom; wdata0 = $urandom; end
        else    begin req  = 0; we  = 1'($urandom); be  = 4'($urandom); addr  = $urandom; wdata  = $urandom; end
        got = 0;
        k   = 0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (d0 ? ready0 : ready) got = 1;
        end
        chk("latency", 64'(k), d0 ? 64'd1 : 64'd3);
        chk("err", 64'(d0 ? err0 : err), 64'(exp_err));
        chk("rdata", 64'(d0 ? rdata0 : rdata), 64'(exp_rd));
        if (d0) last0 = exp_rd; else last2 = exp_rd;
        @(posedge clk); #1;
        chk("ready_pulse", 64'(d0 ? ready0 : ready), 64'd0);
        chk("err_idle", 64'(d0 ? err0 : err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        rst = 1;
        req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
        last2 = 0; last0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0;

        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("idle_ready", 64'(ready), 64'd0);
            chk("idle_err", 64'(err), 64'd0);
            chk("idle_rdata", 64'(rdata), 64'd0);
        end

        access(0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        access(0, 0, 4'hF, 32'h10, 32'h0);
        chk("full_write_read", 64'(rdata), 64'hDEADBEEF);
        access(0, 1, 4'b0001, 32'h10, 32'h00000055);
        access(0, 0, 4'h0, 32'h10, 32'h0);
        chk("partial_write_read", 64'(rdata), 64'hDEADBE55);
        access(0, 1, 4'hF, 32'h0, 32'hA5A5A5A5);
        access(0, 0, 4'hF, 32'h13, 32'h0);
        access(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF);
        access(0, 0, 4'hF, 32'h0, 32'h0);
        chk("word0_intact", 64'(rdata), 64'hA5A5A5A5);
        access(0, 1, 4'h0, 32'h10, 32'h12345678);
        access(0, 0, 4'hF, 32'h10, 32'h0);

        // LATENCY=0 with req held high: captures on every other edge only.
        @(negedge clk);
        req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 32'h40; wdata0 = 32'd1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk("l0_ready", 64'(ready0), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("l0_err", 64'(err0), 64'd0);
            @(negedge clk);
            wdata0 = 32'(k + 1);
            if (k == 8) req0 = 0;
        end
        mdl0[16] = 32'd7;
        access(1, 0, 4'hF, 32'h40, 32'h0);
        access(1, 0, 4'hF, 32'h41, 32'h0);

        // Reset while a write sits in WAIT: the write must be dropped.
        access(0, 1, 4'hF, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        req = 1; we = 1; be = 4'hF; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 0; rst = 1;
        @(posedge clk); #1;
        chk("rst_ready", 64'(ready), 64'd0);
        @(negedge clk); rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("rst_no_ready", 64'(ready), 64'd0);
        end
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rdata0", 64'(rdata0), 64'd0);
        last2 = 0;
        last0 = 0;
        access(0, 0, 4'hF, 32'h20, 32'h0);
        chk("rst_dropped_write", 64'(rdata), 64'hCAFEF00D);

        for (int i = 0; i < 16; i++) begin
            access(0, 1, 4'hF, 32'(i * 4), $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 7))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a + 32'h1000 + 32'($urandom_range(0, 3) * 4);
                default: ;
            endcase
            access(0, 1'($urandom), 4'($urandom), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
